fir_coef_loader: RTL

//  Writer side of the FIR coefficient port: holds NBANK coefficient sets in local RAM and, on command,

---
 rtl/fir_coef_loader_pkg.sv | 28 ++
 rtl/fir_coef_loader_ram.sv | 37 +++
 rtl/fir_coef_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_loader_pkg.sv
// fir_coef_loader_pkg: FSM state type and width helpers shared by the
// FIR coefficient loader and its coefficient table RAM.
package fir_coef_loader_pkg;

   // Load sequencer states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREFETCH = 2'd1,
      LOAD     = 2'd2,
      APPLY    = 2'd3
   } state_e;

   // Tap address width: enough bits to hold taps 0..order.
   function automatic int calc_aw(input int order);
      return (order < 1) ? 1 : $clog2(order + 1);
   endfunction

   // Bank index width: at least one bit, even for a single bank.
   function automatic int calc_bw(input int nbank);
      return (nbank < 2) ? 1 : $clog2(nbank);
   endfunction

   // Flat RAM address width for a table of the given depth.
   function automatic int calc_ram_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fir_coef_loader_ram.sv
// coef_table_ram: simple dual-port coefficient table. One write port fed by
// the CPU table interface, one read port owned by the load sequencer with a
// single-cycle registered read. The read register holds its value while
// rd_en is low so a fetched tap can be replayed on later cycles.
module coef_table_ram #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 64,
   parameter int RAW   = 6
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [RAW-1:0]   wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [RAW-1:0]   rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Table write and registered table read.
   // NOTE: the storage array and read register take no reset; a reset loop
   // over an array prevents RAM inference, and table contents are defined
   // only by CPU writes anyway.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: keeps NBANK coefficient sets in a local table and, on a
// start request, streams one set into a FIR tap by tap (coef_wr/addr/data),
// then pulses coef_mirr so the FIR switches all taps at once.
// Optional build macro FIR_COEF_LOADER_SYM_EN selects symmetric mode: only
// taps 0..ORDER/2 are stored and each is written to addr k and ORDER-k.
module fir_coef_loader
   import fir_coef_loader_pkg::*;
#(
   parameter int  WIDTH_COEF = 18,
   parameter int  ORDER      = 31,
   parameter int  NBANK      = 2,
   localparam int AW         = calc_aw(ORDER),
   localparam int BW         = calc_bw(NBANK)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tbl_wr,
   input  logic [BW-1:0]         tbl_bank,
   input  logic [AW-1:0]         tbl_addr,
   input  logic [WIDTH_COEF-1:0] tbl_data,
   input  logic                  start,
   input  logic [BW-1:0]         start_bank,
   output logic                  coef_wr,
   output logic [AW-1:0]         coef_addr,
   output logic [WIDTH_COEF-1:0] coef_data,
   output logic                  coef_mirr,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int            NTAP     = ORDER + 1;
   localparam int            DEPTH    = NBANK * NTAP;
   localparam int            RAW      = calc_ram_aw(DEPTH);
   localparam logic [AW-1:0] TAP_MAX  = AW'(ORDER);
   localparam logic [AW-1:0] TAP_HALF = AW'(ORDER / 2);

   // Sequencer state.
   state_e        state_q, state_d;
   logic [AW-1:0] tap_q,   tap_d;
   logic [BW-1:0] bank_q,  bank_d;
   logic          err_q,   err_d;
`ifdef FIR_COEF_LOADER_SYM_EN
   localparam bit ORDER_EVEN = (ORDER % 2) == 0;
   // 0: writing tap k to addr k, 1: writing tap k to its mirror addr ORDER-k.
   logic          phase_q, phase_d;
`endif

   // Request qualification.
   logic start_acc;
   logic tbl_bank_ok;
   logic tbl_addr_ok;
   logic tbl_hit;
   logic tbl_wr_en;

   // Table read side and FIR write side.
   logic                  rd_en;
   logic [AW-1:0]         rd_tap;
   logic [RAW-1:0]        wr_ram_addr;
   logic [RAW-1:0]        rd_ram_addr;
   logic [WIDTH_COEF-1:0] rd_data;
   logic                  load_wr;
   logic [AW-1:0]         load_addr;

   // Qualify start requests and CPU table writes against the load in flight.
   // NOTE: combinational blocks use blocking '=' so later lines see earlier
   // results; sequential blocks use '<=' so all flops update together.
   always_comb begin
      start_acc   = start && (state_q == IDLE) && (int'(start_bank) < NBANK);
      tbl_bank_ok = int'(tbl_bank) < NBANK;
`ifdef FIR_COEF_LOADER_SYM_EN
      tbl_addr_ok = tbl_addr <= TAP_HALF;
`else
      tbl_addr_ok = tbl_addr <= TAP_MAX;
`endif
      // A write collides with the bank being streamed, or with the bank a
      // start is latching in this very cycle.
      tbl_hit     = ((state_q != IDLE) && (tbl_bank == bank_q)) ||
                    (start_acc && (tbl_bank == start_bank));
      tbl_wr_en   = tbl_wr && tbl_bank_ok && tbl_addr_ok && !tbl_hit;
      wr_ram_addr = RAW'(int'(tbl_bank) * NTAP + int'(tbl_addr));
   end

   // Next-state, table read requests and FIR write outputs.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      bank_d    = bank_q;
      err_d     = err_q;
`ifdef FIR_COEF_LOADER_SYM_EN
      phase_d   = phase_q;
`endif
      rd_en     = 1'b0;
      rd_tap    = tap_q;
      load_wr   = 1'b0;
      load_addr = '0;

      unique case (state_q)
         IDLE: begin
            if (start_acc) begin
               state_d = PREFETCH;
               bank_d  = start_bank;
               tap_d   = '0;
               err_d   = 1'b0;
`ifdef FIR_COEF_LOADER_SYM_EN
               phase_d = 1'b0;
`endif
            end
         end

         // Fetch tap 0 so its data is ready on the first LOAD cycle.
         PREFETCH: begin
            rd_en   = 1'b1;
            rd_tap  = '0;
            state_d = LOAD;
         end

         LOAD: begin
            load_wr = 1'b1;
`ifdef FIR_COEF_LOADER_SYM_EN
            if (!phase_q) begin
               load_addr = tap_q;
               if (ORDER_EVEN && (tap_q == TAP_HALF)) begin
                  // Centre tap of an even-order filter has no mirror.
                  state_d = APPLY;
               end else begin
                  phase_d = 1'b1;
               end
            end else begin
               load_addr = TAP_MAX - tap_q;
               if (tap_q == TAP_HALF) begin
                  state_d = APPLY;
               end else begin
                  // Fetch the next stored tap while its predecessor's
                  // mirror is being written.
                  rd_en   = 1'b1;
                  rd_tap  = tap_q + AW'(1);
                  tap_d   = tap_q + AW'(1);
                  phase_d = 1'b0;
               end
            end
`else
            load_addr = tap_q;
            if (tap_q == TAP_MAX) begin
               state_d = APPLY;
            end else begin
               rd_en  = 1'b1;
               rd_tap = tap_q + AW'(1);
               tap_d  = tap_q + AW'(1);
            end
`endif
         end

         APPLY: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A colliding table write flags an error even in the cycle a start
      // clears the flag.
      if (tbl_wr && tbl_addr_ok && tbl_hit) begin
         err_d = 1'b1;
      end
   end

   assign rd_ram_addr = RAW'(int'(bank_q) * NTAP + int'(rd_tap));

   // State, tap counter, bank latch and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tap_q   <= '0;
         bank_q  <= '0;
         err_q   <= 1'b0;
`ifdef FIR_COEF_LOADER_SYM_EN
         phase_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         bank_q  <= bank_d;
         err_q   <= err_d;
`ifdef FIR_COEF_LOADER_SYM_EN
         phase_q <= phase_d;
`endif
      end
   end

   coef_table_ram #(
      .WIDTH (WIDTH_COEF),
      .DEPTH (DEPTH),
      .RAW   (RAW)
   ) u_table (
      .clk     (clk),
      .wr_en   (tbl_wr_en),
      .wr_addr (wr_ram_addr),
      .wr_data (tbl_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ram_addr),
      .rd_data (rd_data)
   );

   // Outputs decode straight from registered state; data is forced to zero
   // outside write cycles so the bus is quiet after reset and between loads.
   assign coef_wr   = load_wr;
   assign coef_addr = load_addr;
   assign coef_data = load_wr ? rd_data : '0;
   assign coef_mirr = (state_q == APPLY);
   assign done      = (state_q == APPLY);
   assign busy      = (state_q != IDLE);
   assign err       = err_q;

endmodule
